// File: rtl/color_proc.sv
// Streaming colour filter: reads one camera frame pixel per clock, applies
// the selected filter (pass-through, red key, grey, binary threshold) and
// writes the result into the processed frame buffer two clocks later.
module color_proc #(
    parameter int c_img_cols    = 320,
    parameter int c_img_rows    = 240,
    parameter int c_img_pxls    = c_img_cols * c_img_rows,
    parameter int c_nb_img_pxls = 17,
    parameter int c_nb_buf      = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     cont,
    input  logic [1:0]               mode,
    input  logic [3:0]               thr,
    output logic [c_nb_img_pxls-1:0] orig_img_addr,
    input  logic [c_nb_buf-1:0]      orig_img_pxl,
    output logic [c_nb_img_pxls-1:0] proc_img_addr,
    output logic [c_nb_buf-1:0]      proc_img_pxl,
    output logic                     proc_we,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [c_nb_img_pxls-1:0] c_last_addr = c_nb_img_pxls'(c_img_pxls - 1);
    localparam logic [c_nb_img_pxls-1:0] c_addr_one  = c_nb_img_pxls'(1);

    // FSM state
    state_t state_q, state_d;

    // Scan address counter and flush cycle counter
    logic [c_nb_img_pxls-1:0] addr_q, addr_d;
    logic                     flush_q, flush_d;

    // Filter configuration captured at pass start
    logic [1:0] mode_q, mode_d;
    logic [3:0] thr_q, thr_d;

    // Stage 1: address whose read data is arriving this cycle
    logic                     vld1_q, vld1_d;
    logic [c_nb_img_pxls-1:0] addr1_q, addr1_d;

    // Stage 2: registered write port towards the processed buffer
    logic                     we_q, we_d;
    logic [c_nb_img_pxls-1:0] paddr_q, paddr_d;
    logic [c_nb_buf-1:0]      pxl_q, pxl_d;
    logic                     done_q, done_d;

    // FSM decoded controls
    logic scan_en;
    logic flush_end;
    logic load_cfg;

    // Filter intermediates
    logic [3:0]  pix_r, pix_g, pix_b;
    logic [5:0]  luma_sum;
    logic [3:0]  luma;
    logic        red_ok;
    logic [11:0] filt_pxl;

    // State register
    // NOTE: every flop (pipeline included) is cleared by reset so that all
    // outputs read 0 while rst is high and an aborted pass leaves no write
    // or done pulse in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values, independent of block order.
            state_q <= state_d;
        end
    end

    // Next-state logic; with cont held, FLUSH chains straight into a new SCAN
    always_comb begin
        // NOTE: default first so no path through the case leaves state_d
        // unassigned, which would infer a latch.
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start || cont) begin
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (addr_q == c_last_addr) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (flush_q) begin
                    state_d = cont ? S_SCAN : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: busy flag, scan enable, end-of-flush and config capture
    always_comb begin
        busy      = (state_q != S_IDLE);
        scan_en   = (state_q == S_SCAN);
        flush_end = (state_q == S_FLUSH) && flush_q;
        load_cfg  = ((state_q == S_IDLE) && (start || cont)) || (flush_end && cont);
    end

    // Pixel filter on the read data of the stage-1 address
    always_comb begin
        pix_r    = orig_img_pxl[11:8];
        pix_g    = orig_img_pxl[7:4];
        pix_b    = orig_img_pxl[3:0];
        // Widened to 5 bits so that g+4 / b+4 cannot wrap past 15
        red_ok   = ({1'b0, pix_r} >= ({1'b0, pix_g} + 5'd4)) &&
                   ({1'b0, pix_r} >= ({1'b0, pix_b} + 5'd4));
        // r + 2g + b peaks at 60, so 6 bits hold it exactly
        luma_sum = {2'b00, pix_r} + {1'b0, pix_g, 1'b0} + {2'b00, pix_b};
        luma     = luma_sum[5:2];
        filt_pxl = 12'h000;
        case (mode_q)
            2'd0: filt_pxl = orig_img_pxl[11:0];
            2'd1: filt_pxl = red_ok ? orig_img_pxl[11:0] : 12'h000;
            2'd2: filt_pxl = {luma, luma, luma};
            2'd3: filt_pxl = (luma >= thr_q) ? 12'hFFF : 12'h000;
            default: filt_pxl = 12'h000;
        endcase
    end

    // Next values for counters, configuration and the two pipeline stages
    always_comb begin
        // Address stays at 0 outside SCAN and wraps to 0 on the last pixel
        addr_d = '0;
        if (scan_en && (addr_q != c_last_addr)) begin
            addr_d = addr_q + c_addr_one;
        end

        flush_d = (state_q == S_FLUSH) ? ~flush_q : 1'b0;

        mode_d = load_cfg ? mode : mode_q;
        thr_d  = load_cfg ? thr  : thr_q;

        vld1_d  = scan_en;
        addr1_d = scan_en ? addr_q : '0;

        we_d    = vld1_q;
        paddr_d = vld1_q ? addr1_q : '0;
        pxl_d   = vld1_q ? c_nb_buf'(filt_pxl) : '0;

        done_d = flush_end;
    end

    // Datapath and pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            flush_q <= 1'b0;
            mode_q  <= 2'd0;
            thr_q   <= 4'd0;
            vld1_q  <= 1'b0;
            addr1_q <= '0;
            we_q    <= 1'b0;
            paddr_q <= '0;
            pxl_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            flush_q <= flush_d;
            mode_q  <= mode_d;
            thr_q   <= thr_d;
            vld1_q  <= vld1_d;
            addr1_q <= addr1_d;
            we_q    <= we_d;
            paddr_q <= paddr_d;
            pxl_q   <= pxl_d;
            done_q  <= done_d;
        end
    end

    assign orig_img_addr = addr_q;
    assign proc_img_addr = paddr_q;
    assign proc_img_pxl  = pxl_q;
    assign proc_we       = we_q;
    assign done          = done_q;

endmodule

// File: doc/color_proc.md
COLOR_PROC -- requirements
Module: color_proc

Interface
REQ-001 SHALL have parameters: c_img_cols, default 320, image columns; c_img_rows, default 240, image rows; c_img_pxls, default c_img_cols*c_img_rows, pixels per frame; c_nb_img_pxls, default 17, address width; c_nb_buf, default 12, pixel width.
REQ-002 SHALL have ports, in order:
- clk  in  1  system clock (50 MHz domain).
- rst  in  1  reset; one clock; asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a frame pass.
- cont  in  1  level; restarts passes continuously.
- mode  in  2  filter select, sampled at pass start.
- thr  in  4  grey threshold for mode 3.
- orig_img_addr  out  c_nb_img_pxls  read address to the camera frame buffer.
- orig_img_pxl  in  c_nb_buf  read data, valid one clk after the address.
- proc_img_addr  out  c_nb_img_pxls  write address to the processed frame buffer.
- proc_img_pxl  out  c_nb_buf  processed pixel.
- proc_we  out  1  write enable for the processed buffer.
- busy  out  1  high while a pass is in progress.
- done  out  1  one-cycle pulse when a pass completes.
REQ-003 SHALL use pixel layout: red [11:8], green [7:4], blue [3:0].

Function
REQ-004 SHALL implement FSM states IDLE, SCAN, FLUSH.
REQ-005 IDLE->SCAN SHALL occur when start=1 or cont=1; mode and thr are latched on this transition.
REQ-006 In SCAN, orig_img_addr SHALL increment by 1 each clk from 0 to c_img_pxls-1, then the FSM SHALL go to FLUSH.
REQ-007 FLUSH SHALL last 2 clks to drain the pipeline, then return to IDLE and assert done for 1 clk.
REQ-008 Pipeline latency SHALL be 2 clks: an address issued at t SHALL have its result on proc_img_pxl/proc_img_addr with proc_we=1 at t+2.
REQ-009 proc_we SHALL be high for exactly c_img_pxls clks per pass, with consecutive addresses and no gaps or duplicates.
REQ-010 Mode 0 SHALL pass the pixel through unchanged.
REQ-011 Mode 1 (red filter) SHALL output the pixel if r >= g+4 and r >= b+4; otherwise 0x000. Compares SHALL be 5-bit, with no wrap.
REQ-012 Mode 2 (grey) SHALL compute y = (r + 2g + b) >> 2 using a 6-bit sum, and output {y,y,y}.
REQ-013 Mode 3 (binary) SHALL output 0xFFF if y >= thr, else 0x000.
REQ-014 start SHALL be ignored while busy=1; mode and thr changes mid-pass SHALL have no effect until the next pass.
REQ-015 If cont=1 when FLUSH ends, the FSM SHALL pulse done and enter SCAN on the next clk, re-latching mode and thr.
REQ-016 busy SHALL be 1 in SCAN and FLUSH, and 0 in IDLE.
REQ-017 orig_img_addr SHALL hold 0 in IDLE.
REQ-018 proc_img_addr SHALL never exceed c_img_pxls-1.

Reset
REQ-019 While rst=1, regardless of clk, the FSM SHALL be IDLE and all outputs SHALL be 0.
REQ-020 Reset mid-pass SHALL abort the pass with no further proc_we and no done pulse.
REQ-021 After rst deasserts, the block SHALL remain IDLE until start or cont is high.

Verification
REQ-022 Mode 0, memory model with data = addr[11:0], start pulse -> proc_we high for 76800 clks, each output equal to its address, done 1 clk after the last write.
REQ-023 Mode 1: pixel 0xA31 -> 0xA31; 0x9A2 -> 0x000; 0x555 -> 0x000.
REQ-024 Mode 2: 0xF00 -> 0x333; 0xFFF -> 0xFFF. Mode 3 with thr=8: 0x888 -> 0xFFF, 0x777 -> 0x000.
REQ-025 Second start pulse and a mode change issued mid-pass -> no restart, output still uses the original mode, exactly one done.
REQ-026 rst asserted at address 1000 -> proc_we and busy 0 immediately, no done. With cont=1 after release -> two back-to-back passes, done pulses 76802 clks apart.
